quire_window_arbiter: RTL and testbench

//  Shares one quire_4_0 accumulator among NREQ product streams. Grants are per dot-product

---
 rtl/quire_window_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_quire_window_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quire_window_arbiter.sv
// -----------------------------------------------------------------------------
// quire_window_arbiter
//
// Shares a single quire_4_0 accumulator among NREQ posit product streams.
// A requester is granted the quire for one whole dot-product window (sow beat
// through eow beat); windows are arbitrated round-robin with one IDLE cycle
// between them. The owner of every window that entered the quire is queued in
// a tag FIFO so the window's final (eow) quire result can be routed back to the
// right consumer. Intermediate quire result beats are accepted and dropped.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_rts_i / req_rtr_o      per-requester valid / ready
//   req_sow_i / req_eow_i      per-requester window start / end flags
//   req_fraction_i, req_scale_i  packed 4-bit fields, requester i at [4i+3:4i]
//   req_sign_i, req_zero_i, req_NaR_i  per-requester flags
//   q_*                        owner's beat forwarded to the quire slave port
//   qr_*                       quire master port (results) into the arbiter
//   res_rts_o / res_rtr_i      one-hot result valid / per-consumer ready
//   res_data_o, res_NaR_o, res_sign_o, res_zero_o  shared result bus
//   busy_o                     a window currently owns the quire
// -----------------------------------------------------------------------------
module quire_window_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_rts_i,
    output logic [NREQ-1:0]   req_rtr_o,
    input  logic [NREQ-1:0]   req_sow_i,
    input  logic [NREQ-1:0]   req_eow_i,
    input  logic [4*NREQ-1:0] req_fraction_i,
    input  logic [4*NREQ-1:0] req_scale_i,
    input  logic [NREQ-1:0]   req_sign_i,
    input  logic [NREQ-1:0]   req_zero_i,
    input  logic [NREQ-1:0]   req_NaR_i,
    output logic              q_rts_o,
    input  logic              q_rtr_i,
    output logic              q_sow_o,
    output logic              q_eow_o,
    output logic              q_sign_o,
    output logic              q_zero_o,
    output logic              q_NaR_o,
    output logic [3:0]        q_fraction_o,
    output logic [3:0]        q_scale_o,
    input  logic              qr_rts_i,
    output logic              qr_rtr_o,
    input  logic              qr_eow_i,
    input  logic [18:0]       qr_data_i,
    input  logic              qr_NaR_i,
    input  logic              qr_sign_i,
    input  logic              qr_zero_i,
    output logic [NREQ-1:0]   res_rts_o,
    input  logic [NREQ-1:0]   res_rtr_i,
    output logic [18:0]       res_data_o,
    output logic              res_NaR_o,
    output logic              res_sign_o,
    output logic              res_zero_o,
    output logic              busy_o
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned TAW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  tag_mem_q [TAG_DEPTH];
    logic [TAW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [TAW:0]    count_q;

    logic [NREQ-1:0] eligible;
    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic            own_xfer, push, pop, route, fifo_full, fifo_empty;
    logic [IDW-1:0]  tag;

    // First eligible requester scanning upward from rr_ptr, wrapping at NREQ.
    always_comb begin
        int unsigned idx;
        eligible  = req_rts_i & req_sow_i;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!grant_vld && eligible[idx[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx[IDW-1:0];
            end
        end
    end

    // Owner's beat passes straight through to the quire (no added latency).
    always_comb begin
        q_rts_o   = (state_q == BUSY) && req_rts_i[owner_q];
        req_rtr_o = '0;
        if (state_q == BUSY) begin
            req_rtr_o[owner_q] = q_rtr_i;
        end
        q_sow_o      = req_sow_i[owner_q];
        q_eow_o      = req_eow_i[owner_q];
        q_sign_o     = req_sign_i[owner_q];
        q_zero_o     = req_zero_i[owner_q];
        q_NaR_o      = req_NaR_i[owner_q];
        q_fraction_o = req_fraction_i[{owner_q, 2'b00} +: 4];
        q_scale_o    = req_scale_i[{owner_q, 2'b00} +: 4];
        own_xfer     = q_rts_o && q_rtr_i;
        push         = own_xfer && q_sow_o;
    end

    // Result return: only eow beats with a pending tag are routed; everything
    // else is accepted and discarded so the quire never stalls on it.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == (TAW+1)'(TAG_DEPTH));
        tag        = tag_mem_q[rd_ptr_q];
        route      = qr_rts_i && qr_eow_i && !fifo_empty;
        res_rts_o  = '0;
        res_rts_o[tag] = route;
        qr_rtr_o   = route ? res_rtr_i[tag] : 1'b1;
        pop        = route && res_rtr_i[tag];
        res_data_o = qr_data_i;
        res_NaR_o  = qr_NaR_i;
        res_sign_o = qr_sign_i;
        res_zero_o = qr_zero_i;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (grant_vld && !fifo_full) begin
                    owner_d = grant_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (own_xfer && q_eow_o) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            busy_o   <= (state_d == BUSY);
            if (push) begin
                tag_mem_q[wr_ptr_q] <= owner_q;
                wr_ptr_q <= (wr_ptr_q == TAW'(TAG_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == TAW'(TAG_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quire_window_arbiter.sv
// -----------------------------------------------------------------------------
// tb_quire_window_arbiter
//
// Directed scenarios for window grant, round-robin order, result routing, tag
// FIFO full stall, owner stall and mid-window reset, followed by randomized
// traffic checked cycle by cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_quire_window_arbiter;

    localparam int NREQ      = 4;
    localparam int TAG_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_rts, req_rtr, req_sow, req_eow, req_sign, req_zero, req_nar;
    logic [4*NREQ-1:0] req_frac, req_scale;
    logic              q_rts, q_rtr, q_sow, q_eow, q_sign, q_zero, q_nar;
    logic [3:0]        q_frac, q_scale;
    logic              qr_rts, qr_rtr, qr_eow, qr_nar, qr_sign, qr_zero;
    logic [18:0]       qr_data;
    logic [NREQ-1:0]   res_rts, res_rtr;
    logic [18:0]       res_data;
    logic              res_nar, res_sign, res_zero, busy;

    always #5 clk = ~clk;

    quire_window_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_rts_i(req_rts), .req_rtr_o(req_rtr), .req_sow_i(req_sow), .req_eow_i(req_eow),
        .req_fraction_i(req_frac), .req_scale_i(req_scale), .req_sign_i(req_sign),
        .req_zero_i(req_zero), .req_NaR_i(req_nar),
        .q_rts_o(q_rts), .q_rtr_i(q_rtr), .q_sow_o(q_sow), .q_eow_o(q_eow), .q_sign_o(q_sign),
        .q_zero_o(q_zero), .q_NaR_o(q_nar), .q_fraction_o(q_frac), .q_scale_o(q_scale),
        .qr_rts_i(qr_rts), .qr_rtr_o(qr_rtr), .qr_eow_i(qr_eow), .qr_data_i(qr_data),
        .qr_NaR_i(qr_nar), .qr_sign_i(qr_sign), .qr_zero_i(qr_zero),
        .res_rts_o(res_rts), .res_rtr_i(res_rtr), .res_data_o(res_data),
        .res_NaR_o(res_nar), .res_sign_o(res_sign), .res_zero_o(res_zero), .busy_o(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the quire, where round-robin resumes, the
    // ordered list of window owners awaiting their final result, and how many
    // finished windows still owe an eow result from the quire.
    bit m_busy;
    int m_owner, m_ptr, q_pending;
    int m_tags[$];
    logic            exp_q_rts, exp_qr_rtr;
    logic [NREQ-1:0] exp_req_rtr, exp_res_rts;

    function automatic void model_eval();
        exp_q_rts   = m_busy && req_rts[m_owner];
        exp_req_rtr = '0;
        if (m_busy) exp_req_rtr[m_owner] = q_rtr;
        exp_res_rts = '0;
        exp_qr_rtr  = 1'b1;
        if (qr_rts && qr_eow && m_tags.size() > 0) begin
            exp_res_rts[m_tags[0]] = 1'b1;
            exp_qr_rtr = res_rtr[m_tags[0]];
        end
    endfunction

    task automatic tick();
        bit full, pop;
        model_eval();
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; q_pending = 0;
            m_tags.delete();
        end else begin
            full = (m_tags.size() >= TAG_DEPTH);
            pop  = (exp_res_rts != '0) && exp_qr_rtr;
            if (qr_rts && qr_eow && exp_qr_rtr && q_pending > 0) q_pending--;
            if (pop) void'(m_tags.pop_front());
            if (m_busy) begin
                if (req_rts[m_owner] && q_rtr) begin
                    if (req_sow[m_owner]) m_tags.push_back(m_owner);
                    if (req_eow[m_owner]) begin
                        m_busy = 0;
                        m_ptr = (m_owner + 1) % NREQ;
                        q_pending++;
                    end
                end
            end else if (!full) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (req_rts[(m_ptr + k) % NREQ] && req_sow[(m_ptr + k) % NREQ]) begin
                        m_busy = 1;
                        m_owner = (m_ptr + k) % NREQ;
                        break;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        req_rts = '0; req_sow = '0; req_eow = '0; req_sign = '0; req_zero = '0; req_nar = '0;
        req_frac = '0; req_scale = '0; q_rtr = 1'b0;
        qr_rts = 1'b0; qr_eow = 1'b0; qr_data = '0; qr_nar = 1'b0; qr_sign = 1'b0; qr_zero = 1'b0;
        res_rtr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req_rts = '1; req_sow = '1;
        rst = 1'b1;
        tick();
        #2;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (q_rts !== 1'b0) begin miscompares++; $display("FAIL reset_q_rts: got %b expected 0", q_rts); end
        vectors++; if (req_rtr !== 4'b0000) begin miscompares++; $display("FAIL reset_req_rtr: got %b expected 0000", req_rtr); end
        vectors++; if (res_rts !== 4'b0000) begin miscompares++; $display("FAIL reset_res_rts: got %b expected 0000", res_rts); end
        tick();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_window();
        int b;
        logic [18:0] d;
        do_reset();
        q_rtr = 1'b1;
        for (int c = 0; c < 5; c++) begin
            b = (c == 0) ? 0 : c - 1;
            req_rts  = (c < 4) ? 4'b0001 : 4'b0000;
            req_sow  = {3'b000, b == 0};
            req_eow  = {3'b000, b == 2};
            req_frac = 16'($urandom); req_scale = 16'($urandom);
            req_sign = 4'($urandom); req_zero = 4'($urandom); req_nar = 4'($urandom);
            #2;
            vectors++; if (busy !== (c >= 1 && c <= 3)) begin miscompares++; $display("FAIL t1_busy c=%0d: got %b", c, busy); end
            if (c >= 1 && c <= 3) begin
                vectors++;
                if ({q_rts, q_sow, q_eow, q_sign, q_zero, q_nar, q_frac, q_scale} !==
                    {1'b1, req_sow[0], req_eow[0], req_sign[0], req_zero[0], req_nar[0], req_frac[3:0], req_scale[3:0]}) begin
                    miscompares++; $display("FAIL t1_forward c=%0d: got %b expected %b", c,
                        {q_rts, q_sow, q_eow, q_sign, q_zero, q_nar, q_frac, q_scale},
                        {1'b1, req_sow[0], req_eow[0], req_sign[0], req_zero[0], req_nar[0], req_frac[3:0], req_scale[3:0]});
                end
                vectors++; if (req_rtr !== 4'b0001) begin miscompares++; $display("FAIL t1_req_rtr: got %b expected 0001", req_rtr); end
            end
            tick();
        end
        idle_inputs();
        res_rtr = '1;
        qr_rts = 1'b1; qr_eow = 1'b0; qr_data = 19'($urandom);
        #2;
        vectors++; if ({qr_rtr, res_rts} !== 5'b10000) begin miscompares++; $display("FAIL t1_intermediate: got rtr=%b res=%b expected 1/0000", qr_rtr, res_rts); end
        tick();
        d = 19'($urandom);
        qr_eow = 1'b1; qr_data = d; qr_sign = 1'b1;
        #2;
        vectors++; if (res_rts !== 4'b0001) begin miscompares++; $display("FAIL t1_res_rts: got %b expected 0001", res_rts); end
        vectors++; if ({res_data, res_sign} !== {d, 1'b1}) begin miscompares++; $display("FAIL t1_res_data: got %h expected %h", res_data, d); end
        tick();
        #2;
        vectors++; if ({qr_rtr, res_rts} !== 5'b10000) begin miscompares++; $display("FAIL t1_after_pop: got rtr=%b res=%b expected 1/0000", qr_rtr, res_rts); end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int got[$];
        int expect_order[5] = '{0, 2, 3, 0, 1};
        logic [NREQ-1:0] pend, taken;
        do_reset();
        q_rtr = 1'b1; res_rtr = '1; qr_eow = 1'b1;
        pend = 4'b0101;
        for (int c = 0; c < 120 && got.size() < 5; c++) begin
            if (got.size() == 2 && pend == '0) pend = 4'b1011;
            req_rts = pend; req_sow = pend; req_eow = pend;
            qr_rts = (q_pending > 0);
            qr_data = 19'($urandom);
            #2;
            taken = req_rtr & req_rts;
            for (int i = 0; i < NREQ; i++) if (taken[i]) got.push_back(i);
            tick();
            pend = pend & ~taken;
        end
        vectors++; if (got.size() != 5) begin miscompares++; $display("FAIL t2_grant_count: got %0d expected 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            vectors++; if (got[i] != expect_order[i]) begin miscompares++; $display("FAIL t2_order[%0d]: got %0d expected %0d", i, got[i], expect_order[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_alternating();
        int rem1 = 4, rem3 = 4;
        logic [NREQ-1:0] got[$];
        do_reset();
        q_rtr = 1'b1; res_rtr = '1; qr_eow = 1'b1;
        for (int c = 0; c < 200 && got.size() < 8; c++) begin
            req_rts = {rem3 > 0, 1'b0, rem1 > 0, 1'b0};
            req_sow = req_rts; req_eow = req_rts;
            qr_rts = (q_pending > 0);
            qr_data = 19'($urandom);
            #2;
            if (qr_rts && res_rts != '0) begin
                got.push_back(res_rts);
                vectors++; if (res_data !== qr_data) begin miscompares++; $display("FAIL t3_res_data: got %h expected %h", res_data, qr_data); end
            end
            if (req_rtr[1] && req_rts[1]) rem1--;
            if (req_rtr[3] && req_rts[3]) rem3--;
            tick();
        end
        vectors++; if (got.size() != 8) begin miscompares++; $display("FAIL t3_result_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== ((i % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                miscompares++; $display("FAIL t3_tag[%0d]: got %b expected %b", i, got[i], (i % 2 == 0) ? 4'b0010 : 4'b1000);
            end
        end
        idle_inputs();
    endtask

    task automatic test_tag_full();
        int grants = 0;
        do_reset();
        q_rtr = 1'b1;
        req_rts = 4'b0001; req_sow = 4'b0001; req_eow = 4'b0001;
        for (int c = 0; c < 30; c++) begin
            #2;
            if (req_rtr[0]) grants++;
            tick();
        end
        vectors++; if (grants != 4) begin miscompares++; $display("FAIL t4_windows_before_stall: got %0d expected 4", grants); end
        #2;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t4_stalled_idle: got busy=%b expected 0", busy); end
        qr_rts = 1'b1; qr_eow = 1'b1; res_rtr = 4'b0001; qr_data = 19'($urandom);
        #1;
        vectors++; if ({res_rts, qr_rtr} !== 5'b00011) begin miscompares++; $display("FAIL t4_release: got res=%b rtr=%b expected 0001/1", res_rts, qr_rtr); end
        tick();
        qr_rts = 1'b0; res_rtr = '0;
        for (int c = 0; c < 5; c++) begin
            #2;
            if (req_rtr[0]) grants++;
            tick();
        end
        vectors++; if (grants != 5) begin miscompares++; $display("FAIL t4_resume: got %0d windows expected 5", grants); end
        idle_inputs();
    endtask

    task automatic test_owner_stall();
        do_reset();
        q_rtr = 1'b1;
        req_rts = 4'b0100; req_sow = 4'b0100;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            req_rts = 4'b0011; req_sow = 4'b0011; req_eow = 4'b0011;
            #2;
            vectors++;
            if ({busy, q_rts, req_rtr} !== 6'b100100) begin
                miscompares++; $display("FAIL t5_stall c=%0d: got busy=%b q_rts=%b rtr=%b expected 1/0/0100", c, busy, q_rts, req_rtr);
            end
            tick();
        end
        req_rts = 4'b0111; req_sow = 4'b0011; req_eow = 4'b0111;
        #2;
        vectors++; if ({q_rts, req_rtr} !== 5'b10100) begin miscompares++; $display("FAIL t5_resume: got q_rts=%b rtr=%b expected 1/0100", q_rts, req_rtr); end
        tick();
        req_rts = 4'b0011;
        #2;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t5_idle_gap: got busy=%b expected 0", busy); end
        tick();
        #2;
        vectors++; if (req_rtr !== 4'b0001) begin miscompares++; $display("FAIL t5_next_grant: got %b expected 0001", req_rtr); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_busy();
        do_reset();
        q_rtr = 1'b1;
        req_rts = 4'b0010; req_sow = 4'b0010;
        tick();
        tick();
        req_sow = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        qr_rts = 1'b1; qr_eow = 1'b1; res_rtr = '1;
        #2;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t6_busy: got %b expected 0", busy); end
        vectors++; if (res_rts !== 4'b0000) begin miscompares++; $display("FAIL t6_res_rts: got %b expected 0000", res_rts); end
        vectors++; if ({q_rts, req_rtr} !== 5'b00000) begin miscompares++; $display("FAIL t6_req_side: got q_rts=%b rtr=%b expected 0/0000", q_rts, req_rtr); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random_traffic();
        int len[NREQ], beat[NREQ];
        do_reset();
        for (int i = 0; i < NREQ; i++) begin len[i] = 1 + $urandom_range(3); beat[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_rts[i] = ($urandom_range(3) != 0);
                req_sow[i] = (beat[i] == 0);
                req_eow[i] = (beat[i] == len[i] - 1);
            end
            req_frac = 16'($urandom); req_scale = 16'($urandom);
            req_sign = 4'($urandom); req_zero = 4'($urandom); req_nar = 4'($urandom);
            q_rtr   = ($urandom_range(3) != 0);
            qr_rts  = 1'($urandom);
            qr_eow  = (q_pending > 0) && 1'($urandom);
            qr_data = 19'($urandom); qr_nar = 1'($urandom); qr_sign = 1'($urandom); qr_zero = 1'($urandom);
            res_rtr = 4'($urandom);
            #2;
            model_eval();
            vectors++; if (busy !== m_busy) begin miscompares++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, m_busy); end
            vectors++; if ({q_rts, req_rtr} !== {exp_q_rts, exp_req_rtr}) begin
                miscompares++; $display("FAIL rnd_grant c=%0d: got q_rts=%b rtr=%b expected %b/%b", c, q_rts, req_rtr, exp_q_rts, exp_req_rtr);
            end
            if (m_busy) begin
                vectors++;
                if ({q_sow, q_eow, q_sign, q_zero, q_nar, q_frac, q_scale} !==
                    {req_sow[m_owner], req_eow[m_owner], req_sign[m_owner], req_zero[m_owner], req_nar[m_owner],
                     req_frac[4*m_owner +: 4], req_scale[4*m_owner +: 4]}) begin
                    miscompares++; $display("FAIL rnd_forward c=%0d owner=%0d: got %b", c, m_owner,
                        {q_sow, q_eow, q_sign, q_zero, q_nar, q_frac, q_scale});
                end
            end
            if (qr_rts) begin
                vectors++; if ({res_rts, qr_rtr} !== {exp_res_rts, exp_qr_rtr}) begin
                    miscompares++; $display("FAIL rnd_route c=%0d: got res=%b rtr=%b expected %b/%b", c, res_rts, qr_rtr, exp_res_rts, exp_qr_rtr);
                end
            end
            if (exp_res_rts != '0) begin
                vectors++; if ({res_data, res_nar, res_sign, res_zero} !== {qr_data, qr_nar, qr_sign, qr_zero}) begin
                    miscompares++; $display("FAIL rnd_res_data c=%0d: got %h expected %h", c, res_data, qr_data);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_req_rtr[i] && req_rts[i]) begin
                    if (beat[i] == len[i] - 1) begin beat[i] = 0; len[i] = 1 + $urandom_range(3); end
                    else beat[i]++;
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_busy = 0; m_owner = 0; m_ptr = 0; q_pending = 0;
        #1;
        test_reset();
        test_single_window();
        test_round_robin();
        test_alternating();
        test_tag_full();
        test_owner_stall();
        test_reset_busy();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
